fetch_unit: RTL and testbench

Instruction fetch stage of the RV32I core: owns the program counter, issues requests to instruction memory over a req/ack handshake, and presents one instruction at a time to decode/execute. It sits directly upstream of `branch_unit`. It supplies `pc_current` to `branch_unit` and consumes `take_branch`/`branch_target` (plus jump redirects) to choose the next PC. It also flags and halts on misaligned fetch targets.

---
 rtl/fetch_unit.sv | 82 ++++++++
 tb/tb_fetch_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the req/ack handshake to instruction
// memory and holds one instruction at a time for decode, halting on misaligned targets.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        take_branch,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc_current,
  output logic [31:0] pc_plus4,
  output logic        misaligned
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] VALID = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        fault;

  // Outputs decode registered state only; no input reaches imem_req/imem_addr.
  assign imem_req    = (state == REQ);
  assign imem_addr   = pc;
  assign instr_valid = (state == VALID);
  assign pc_current  = pc;
  assign pc_plus4    = pc + 32'd4;
  assign misaligned  = fault;

  always_comb begin
    next_pc = pc_plus4;
    if (jump)             next_pc = jump_target;
    else if (take_branch) next_pc = branch_target;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
      instr <= NOP;
      fault <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (imem_ack) begin
            instr <= imem_rdata;
            state <= VALID;
          end
        end
        VALID: begin
          if (!stall) begin
            // The faulting target stays in pc so it is visible while halted.
            pc <= next_pc;
            if (next_pc[1:0] != 2'b00) begin
              state <= HALT;
              fault <= 1'b1;
            end else begin
              state <= REQ;
            end
          end
        end
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, wait states, redirects, stall, misalignment, wrap.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        take_branch;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc_current;
  logic [31:0] pc_plus4;
  logic        misaligned;

  int checks = 0;
  int failures = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .take_branch(take_branch), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid),
    .pc_current(pc_current), .pc_plus4(pc_plus4), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // In REQ: return rdata with a zero-wait ack, landing in VALID.
  task automatic fetch(input logic [31:0] data);
    imem_ack = 1'b1;
    imem_rdata = data;
    step();
    imem_ack = 1'b0;
  endtask

  // In VALID: jump to target, landing in REQ at target.
  task automatic redirect(input logic [31:0] target);
    jump = 1'b1;
    jump_target = target;
    step();
    jump = 1'b0;
  endtask

  initial begin
    rst = 1'b1; take_branch = 1'b0; branch_target = '0; jump = 1'b0;
    jump_target = '0; stall = 1'b0; imem_ack = 1'b0; imem_rdata = '0;

    // Reset state
    step();
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_mis", misaligned, 0);
    chk("rst_pc", pc_current, 32'h0);
    chk("rst_pc4", pc_plus4, 32'h4);
    chk("rst_instr", instr, 32'h0000_0013);
    rst = 1'b0;

    // First fetch, zero wait
    step();
    chk("f1_req", imem_req, 1);
    chk("f1_addr", imem_addr, 32'h0);
    fetch(32'h0050_0093);
    chk("f1_valid", instr_valid, 1);
    chk("f1_instr", instr, 32'h0050_0093);
    chk("f1_pc4", pc_plus4, 32'h4);
    chk("f1_req_lo", imem_req, 0);

    // Sequential with 3 wait states: req held 4 cycles at addr 4
    step();
    for (int i = 0; i < 3; i++) begin
      chk("ws_req", imem_req, 1);
      chk("ws_addr", imem_addr, 32'h4);
      chk("ws_valid", instr_valid, 0);
      step();
    end
    chk("ws_req4", imem_req, 1);
    chk("ws_addr4", imem_addr, 32'h4);
    fetch(32'h0010_0113);
    chk("ws_instr", instr, 32'h0010_0113);
    chk("ws_pc", pc_current, 32'h4);
    step();
    chk("seq_addr", imem_addr, 32'h8);

    // Taken branch from pc=100
    fetch(32'h1);
    redirect(32'd100);
    fetch(32'h2);
    chk("br_pc", pc_current, 32'd100);
    take_branch = 1'b1; branch_target = 32'd116;
    step();
    take_branch = 1'b0;
    chk("br_addr", imem_addr, 32'd116);
    chk("br_req", imem_req, 1);

    // Not taken from pc=100
    fetch(32'h3);
    redirect(32'd100);
    fetch(32'h4);
    step();
    chk("nt_addr", imem_addr, 32'd104);

    // Stall 5 cycles with redirects present, then jump beats branch
    fetch(32'h5);
    stall = 1'b1; jump = 1'b1; jump_target = 32'd200;
    take_branch = 1'b1; branch_target = 32'd116;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("st_pc", pc_current, 32'd104);
      chk("st_instr", instr, 32'h5);
      chk("st_req", imem_req, 0);
      chk("st_valid", instr_valid, 1);
    end
    stall = 1'b0;
    step();
    jump = 1'b0; take_branch = 1'b0;
    chk("jp_addr", imem_addr, 32'd200);

    // Wrap-around
    fetch(32'h6);
    redirect(32'hFFFF_FFFC);
    fetch(32'h7);
    chk("wr_pc4", pc_plus4, 32'h0);
    step();
    chk("wr_addr", imem_addr, 32'h0);
    chk("wr_req", imem_req, 1);

    // Misaligned branch target, ack and redirects ignored in HALT
    fetch(32'h8);
    take_branch = 1'b1; branch_target = 32'd102;
    step();
    chk("mis_flag", misaligned, 1);
    chk("mis_pc", pc_current, 32'd102);
    imem_ack = 1'b1; jump = 1'b1; jump_target = 32'd400;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("halt_req", imem_req, 0);
      chk("halt_valid", instr_valid, 0);
      chk("halt_mis", misaligned, 1);
      chk("halt_pc", pc_current, 32'd102);
    end
    imem_ack = 1'b0; jump = 1'b0; take_branch = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rec_pc", pc_current, 32'h0);
    chk("rec_mis", misaligned, 0);
    // ack in IDLE must be ignored
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    chk("rec_req", imem_req, 1);
    chk("rec_instr", instr, 32'h0000_0013);
    chk("rec_addr", imem_addr, 32'h0);

    // Reset mid-request
    step();
    chk("mr_pre_req", imem_req, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_req", imem_req, 0);
    chk("mr_valid", instr_valid, 0);
    step();
    chk("mr_idle_exit", imem_req, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
